// File: rtl/timer.sv
// timer: start/pause elapsed-time counter with packed-BCD output (00..MAX_COUNT).
// Counts while start is high, holds while low, clears asynchronously on reset.
// A prescaler divides enabled clocks by TICK_DIV to form one count unit.
// Operating modes (no state output): IDLE = count 00 with start low,
// RUN = start high, PAUSE = start low with nonzero count. IDLE and PAUSE
// both simply hold, so the mode never needs a register of its own.
module timer #(
  parameter int TICK_DIV  = 1,   // enabled clocks per increment, >= 1
  parameter int MAX_COUNT = 99   // terminal decimal value, 1..99
) (
  input  logic       clk,
  input  logic       reset,      // asynchronous, active-low
  input  logic       start,      // level-sensitive run enable
  output logic [7:0] timer_time  // [7:4] tens, [3:0] units
);

  // A one-bit prescaler is kept for TICK_DIV = 1 so the declarations stay
  // legal; it is tied to zero and is removed by synthesis.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [3:0] MAX_TENS  = 4'(MAX_COUNT / 10);
  localparam logic [3:0] MAX_UNITS = 4'(MAX_COUNT % 10);
  localparam logic [7:0] MAX_BCD   = {MAX_TENS, MAX_UNITS};

  logic [PW-1:0] prescale_reg;
  logic [PW-1:0] prescale_next;
  logic          advance;
  logic [7:0]    count_reg;
  logic [7:0]    count_next;

  // Prescaler: steps only while running, so a partial prescale survives a pause.
  always_comb begin
    advance       = 1'b0;
    prescale_next = prescale_reg;
    if (start) begin
      if (TICK_DIV == 1) begin
        advance       = 1'b1;
        prescale_next = '0;
      end else if (prescale_reg == PW'(TICK_DIV - 1)) begin
        advance       = 1'b1;
        prescale_next = '0;
      end else begin
        prescale_next = prescale_reg + PW'(1);
      end
    end
  end

  // BCD increment with wrap from MAX_COUNT straight to 00 on the same edge.
  always_comb begin
    count_next = count_reg;
    if (advance) begin
      if (count_reg == MAX_BCD) begin
        count_next = 8'h00;
      end else if (count_reg[3:0] == 4'd9) begin
        count_next = {count_reg[7:4] + 4'd1, 4'd0};
      end else begin
        count_next = {count_reg[7:4], count_reg[3:0] + 4'd1};
      end
    end
  end

  // All state lives here; reset clears count and prescaler without a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg    <= 8'h00;
      prescale_reg <= '0;
    end else begin
      count_reg    <= count_next;
      prescale_reg <= prescale_next;
    end
  end

  assign timer_time = count_reg;

endmodule

// File: tb/tb_timer.sv
// tb_timer: directed checks of timer for TICK_DIV = 1, TICK_DIV = 4 and MAX_COUNT = 59.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_timer;

  logic       clk = 1'b0;
  logic       reset_a, start_a, reset_b, start_b, reset_c, start_c;
  logic [7:0] time_a, time_b, time_c;
  int         total = 0;
  int         bad   = 0;
  int         model_c;

  always #5 clk = ~clk;

  timer #(.TICK_DIV(1), .MAX_COUNT(99)) dut_a (
    .clk(clk), .reset(reset_a), .start(start_a), .timer_time(time_a));
  timer #(.TICK_DIV(4), .MAX_COUNT(99)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .timer_time(time_b));
  timer #(.TICK_DIV(1), .MAX_COUNT(59)) dut_c (
    .clk(clk), .reset(reset_c), .start(start_c), .timer_time(time_c));

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_a = 1'b0; start_a = 1'b0;
    reset_b = 1'b0; start_b = 1'b0;
    reset_c = 1'b0; start_c = 1'bx;
    #1;
    chk("a_reset", time_a, 8'h00);
    ticks(1);
    chk("a_reset_held", time_a, 8'h00);
    chk("c_reset_x", time_c, 8'h00);

    // Basic run: digits step 00..09,10, never 0A.
    reset_a = 1'b1; start_a = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      ticks(1);
      chk("a_run", time_a, to_bcd(i));
    end
    start_a = 1'b0;
    ticks(3);
    chk("a_hold", time_a, 8'h10);

    // Reset while paused clears before any clock edge.
    @(posedge clk); #2;
    reset_a = 1'b0;
    #1;
    chk("a_async_clr", time_a, 8'h00);
    ticks(1);
    reset_a = 1'b1; start_a = 1'b1;
    ticks(16);
    chk("a_run16", time_a, 8'h16);

    // Wrap 99 -> 00 -> 01.
    ticks(83);
    chk("a_at99", time_a, 8'h99);
    ticks(1);
    chk("a_wrap", time_a, 8'h00);
    ticks(1);
    chk("a_after_wrap", time_a, 8'h01);

    // Async reset mid-run at 37.
    ticks(36);
    chk("a_at37", time_a, 8'h37);
    @(posedge clk); #2;
    reset_a = 1'b0;
    #1;
    chk("a_midrun_clr", time_a, 8'h00);
    ticks(1);
    reset_a = 1'b1;
    ticks(1);
    chk("a_resume01", time_a, 8'h01);

    // Prescale by 4: partial prescale kept across a pause.
    reset_b = 1'b1; start_b = 1'b1;
    ticks(10);
    chk("b_run10", time_b, 8'h02);
    start_b = 1'b0;
    ticks(5);
    chk("b_pause", time_b, 8'h02);
    start_b = 1'b1;
    ticks(1);
    chk("b_resume1", time_b, 8'h02);
    ticks(1);
    chk("b_resume2", time_b, 8'h03);

    // MAX_COUNT = 59: wraps 59 -> 00 and never exceeds 59.
    reset_c = 1'b1; start_c = 1'b1;
    ticks(59);
    chk("c_at59", time_c, 8'h59);
    ticks(1);
    chk("c_wrap", time_c, 8'h00);
    model_c = 0;
    for (int i = 0; i < 200; i++) begin
      ticks(1);
      model_c = (model_c + 1) % 60;
      chk("c_seq", time_c, to_bcd(model_c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer.md
Name: timer

Overview:
- Start/pause elapsed-time counter with an 8-bit packed-BCD output (00–99).
- Counts up while `start` is high. Holds its value while `start` is low. Clears on reset.
- Used as a stopwatch-style timing block in the clock/timing circuits library.
- An internal prescaler sets how many enabled clocks make one count unit.

Parameters:
- TICK_DIV, 1, number of enabled clock cycles per count increment (≥1). Sim default 1; silicon value is set from the clock frequency.
- MAX_COUNT, 99, terminal decimal value. The count after MAX_COUNT wraps to 00. Must be in the range 1..99.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  run enable, level-sensitive: 1 = run, 0 = pause/hold.
- timer_time  output  8  current count, packed BCD: [7:4] = tens digit, [3:0] = units digit.

Behaviour:
- Single clock domain; one clock (`clk`). Reset is asynchronous and active-low (`reset`).
- Reset low:
  - `timer_time` is forced to 8'h00 and the prescaler is cleared immediately, with no clock needed.
  - State is held while `reset` stays low. `start` is ignored and may be X.
- Reset release: the first counting edge is the first rising edge at which `reset` is high and `start` is 1.
- Registered output: `timer_time` comes directly from flops, with no combinational path from `start`.
- States:
  - IDLE: after reset, count 00, `start` = 0.
  - RUN: `start` = 1.
  - PAUSE: `start` = 0 with a nonzero count.
  - IDLE and PAUSE behave identically (hold). The distinction is informative only; no state output is required.
- Prescaler (ceil(log2(TICK_DIV)) bits, or no register when TICK_DIV = 1):
  - On each rising edge with `start` = 1, the prescaler increments.
  - When the prescaler equals TICK_DIV−1, it reloads to 0 and the count advances by one.
  - With TICK_DIV = 1, the count advances on every edge where `start` = 1.
- Hold: with `start` = 0, neither the prescaler nor the count changes, so the partial prescale is preserved across pause/resume.
- BCD increment:
  - If the units digit is 9: units → 0 and tens increments.
  - Otherwise units increments.
  - Digits never take values A–F.
- Wrap: when the count equals MAX_COUNT (BCD) and an advance occurs, the count goes to 8'h00 on the same edge. There is no saturation and no carry output.
- Latency: `start` rising before edge N gives the first increment visible after edge N (TICK_DIV = 1). `start` falling before edge M means no change at edge M.
- Reset mid-run: the count clears asynchronously. If `start` is still 1 at release, counting resumes from 00 on the next edge.
- Reset and `start` changing at the same time: reset dominates.
- X on `start` while out of reset is undefined input. The design need not tolerate it, but must not corrupt state while `reset` is low.
- Synthesizable; no latches; all flops on a single async-reset process.

Test Plan:
- Basic run/pause/resume (clk 10 ns, TICK_DIV = 1):
  - Hold `reset` = 0 for 10 ns → `timer_time` = 8'h00.
  - Release reset with `start` = 1 for 100 ns (10 edges) → 8'h10. Digits step 00,01,…,09,10 (never 0A).
  - Drop `start` for 30 ns → output holds 8'h10.
- Reset while paused:
  - Pulse `reset` low for 10 ns → 8'h00 immediately, before the next clock edge.
  - Release with `start` = 1 for 160 ns → 8'h16.
- Wrap: run 99 edges → 8'h99; the next enabled edge → 8'h00; continue → 8'h01.
- Prescale (TICK_DIV = 4):
  - `start` high for 10 edges → 8'h02.
  - Pause 5 edges, then resume 2 edges → 8'h03. This proves the partial prescale is retained.
- Async reset mid-run: assert `reset` low between clock edges while counting at 8'h37 → output reads 8'h00 within the same cycle. Release with `start` = 1 → 8'h01 after one edge.
- MAX_COUNT = 59: from 8'h59, one enabled advance → 8'h00; the output never exceeds 8'h59 over 200 edges.
